// File: rtl/xrv1_dmem_resp.sv
// XRV1 data-memory responder: single-outstanding load/store slave backed by a
// word-organised SRAM, with a fixed number of wait states per access.
module xrv1_dmem_resp #(
    parameter int unsigned mem_size_p    = 16,
    parameter logic [31:0] base_addr_p   = 32'h0000_0000,
    parameter int unsigned wait_cycles_p = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmem_req_vld_i,
    output logic        dmem_req_rdy_o,
    input  logic [31:0] dmem_req_addr_i,
    input  logic        dmem_req_w_en_i,
    input  logic [3:0]  dmem_req_w_be_i,
    input  logic [31:0] dmem_req_w_data_i,
    output logic        dmem_resp_vld_o,
    output logic        dmem_resp_err_o,
    output logic [31:0] dmem_resp_r_data_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned WORDS     = 1 << (mem_size_p - 2);
    localparam int unsigned IDX_W     = mem_size_p - 2;
    localparam logic [3:0]  WAIT_INIT = 4'(wait_cycles_p);
    localparam state_t      ACCEPT_NEXT = (wait_cycles_p > 0) ? ST_WAIT : ST_RESP;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_resp_vld;
    logic              r_resp_err;
    logic [31:0]       r_resp_data;
    logic [31:0]       r_mem [WORDS];

    logic [31:0]       w_offset;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_accept;
    logic              w_wr_en;
    logic              w_unused_low_bits;

    // Handshake: a request transfers on the rising edge where vld && rdy.
    // rdy depends only on state, so the requester holds addr/data stable while
    // vld is high and rdy is low. Responses are one-cycle pulses, no backpressure.
    assign dmem_req_rdy_o = (r_state == ST_IDLE) || (r_state == ST_RESP);

    assign w_offset          = dmem_req_addr_i - base_addr_p;
    assign w_in_range        = (w_offset[31:mem_size_p] == '0);
    assign w_idx             = w_offset[mem_size_p-1:2];
    assign w_unused_low_bits = ^w_offset[1:0];

    // Reset dominates: no accept, hence no SRAM write, while rst_i is low.
    assign w_accept = rst_i && dmem_req_vld_i && dmem_req_rdy_o;
    assign w_wr_en  = w_accept && dmem_req_w_en_i && w_in_range;

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_req_w_be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= dmem_req_w_data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_resp_vld  <= 1'b0;
            r_resp_err  <= 1'b0;
            r_resp_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        r_cnt       <= WAIT_INIT;
                        r_state     <= ACCEPT_NEXT;
                        r_resp_vld  <= (ACCEPT_NEXT == ST_RESP);
                        r_resp_err  <= !w_in_range;
                        r_resp_data <= (w_in_range && !dmem_req_w_en_i) ? r_mem[w_idx] : 32'd0;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_resp_vld <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state    <= ST_RESP;
                        r_resp_vld <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_resp_vld <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_resp_vld_o    = r_resp_vld;
    assign dmem_resp_err_o    = r_resp_err;
    assign dmem_resp_r_data_o = r_resp_data;
    assign dbg_state_o        = r_state;

endmodule

// File: tb/tb_xrv1_dmem_resp.sv
// Bench for xrv1_dmem_resp: three configurations (wait 0/3/5, various bases),
// directed cases plus randomized traffic checked against a queue-based model.
module tb_xrv1_dmem_resp;

    localparam int NI = 3;
    localparam int          MS   [NI] = '{16, 8, 6};
    localparam logic [31:0] BASE [NI] = '{32'h8000_0000, 32'h0000_0100, 32'h0000_0000};
    localparam int          WC   [NI] = '{0, 3, 5};

    logic        clk = 1'b0;
    logic        rst_n     [NI];
    logic        req_vld   [NI];
    logic        req_rdy   [NI];
    logic [31:0] req_addr  [NI];
    logic        req_we    [NI];
    logic [3:0]  req_be    [NI];
    logic [31:0] req_wdata [NI];
    logic        resp_vld  [NI];
    logic        resp_err  [NI];
    logic [31:0] resp_data [NI];
    logic [1:0]  dbg       [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        xrv1_dmem_resp #(
            .mem_size_p   (MS[g]),
            .base_addr_p  (BASE[g]),
            .wait_cycles_p(WC[g])
        ) u_dut (
            .clk_i             (clk),
            .rst_i             (rst_n[g]),
            .dmem_req_vld_i    (req_vld[g]),
            .dmem_req_rdy_o    (req_rdy[g]),
            .dmem_req_addr_i   (req_addr[g]),
            .dmem_req_w_en_i   (req_we[g]),
            .dmem_req_w_be_i   (req_be[g]),
            .dmem_req_w_data_i (req_wdata[g]),
            .dmem_resp_vld_o   (resp_vld[g]),
            .dmem_resp_err_o   (resp_err[g]),
            .dmem_resp_r_data_o(resp_data[g]),
            .dbg_state_o       (dbg[g])
        );
    end

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          drop_cnt = 0;
    bit          mon_en = 1'b0;
    // entry: {inst[1:0], err, data[31:0], response cycle[19:0]}
    logic [54:0] exp_q [$];
    logic [54:0] mon_e;
    logic [31:0] mm [int];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NI; k++) begin
                if (resp_vld[k] === 1'b1) begin
                    checks++;
                    if (k == 2) drop_cnt++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp inst %0d cycle %0d: got a response, required none", k, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e[54:53] != 2'(k) || mon_e[52] !== resp_err[k] ||
                            mon_e[51:20] !== resp_data[k] || mon_e[19:0] != 20'(cyc)) begin
                            errors++;
                            $display("FAIL resp inst %0d: got err=%0b data=%h cycle=%0d, required inst %0d err=%0b data=%h cycle=%0d",
                                     k, resp_err[k], resp_data[k], cyc,
                                     mon_e[54:53], mon_e[52], mon_e[51:20], mon_e[19:0]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s inst %0d cycle %0d: got %h, required %h", name, k, cyc, act, exp_v);
        end
    endtask

    function automatic int key(input int k, input logic [31:0] off);
        return (k << 20) | int'(off >> 2);
    endfunction

    // Reference model: computes the response from the request fields at accept time.
    task automatic model_accept(input int k, input bit push);
        logic [31:0] off;
        logic [31:0] word;
        logic [31:0] rdata;
        bit          inr;
        int          kk;
        off   = req_addr[k] - BASE[k];
        inr   = (off >> MS[k]) == 0;
        kk    = key(k, off);
        rdata = 32'd0;
        if (req_we[k]) begin
            if (inr) begin
                word = mm.exists(kk) ? mm[kk] : 32'd0;
                for (int b = 0; b < 4; b++)
                    if (req_be[k][b]) word[8*b +: 8] = req_wdata[k][8*b +: 8];
                mm[kk] = word;
            end
        end else if (inr) begin
            rdata = mm.exists(kk) ? mm[kk] : 32'd0;
        end
        if (push) exp_q.push_back({2'(k), !inr, rdata, 20'(cyc + 1 + WC[k])});
    endtask

    task automatic set_req(input int k, input bit we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
        req_vld[k]   = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_be[k]    = be;
        req_wdata[k] = data;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic wait_accept(input int k, input bit push);
        int n;
        n = 0;
        while (req_rdy[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst %0d: rdy stayed low for %0d cycles, required high", k, n);
            req_vld[k] = 1'b0;
        end else begin
            model_accept(k, push);
            @(negedge clk);
        end
    endtask

    task automatic req(input int k, input bit we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
        set_req(k, we, addr, be, data);
        wait_accept(k, 1'b1);
    endtask

    task automatic idle(input int k);
        req_vld[k] = 1'b0;
    endtask

    task automatic check_reset_outputs(input int k);
        check("rst_rdy",   k, 32'(req_rdy[k]),  32'd1);
        check("rst_vld",   k, 32'(resp_vld[k]), 32'd0);
        check("rst_err",   k, 32'(resp_err[k]), 32'd0);
        check("rst_rdata", k, resp_data[k],     32'd0);
        check("rst_state", k, 32'(dbg[k]),      32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pa [6];
        logic [31:0] addr;
        int          d0;
        int          words;

        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0;
            req_vld[k] = 1'b0;
            req_we[k] = 1'b0;
            req_addr[k] = 32'd0;
            req_be[k] = 4'd0;
            req_wdata[k] = 32'd0;
        end
        @(negedge clk);
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < NI; k++) check_reset_outputs(k);
        repeat (5) @(negedge clk);

        // wait=0: store then load of the same word, back to back
        req(0, 1'b1, BASE[0] + 32'h10, 4'hF, 32'hDEAD_BEEF);
        req(0, 1'b0, BASE[0] + 32'h10, 4'h0, 32'h0);
        idle(0);
        repeat (3) @(negedge clk);

        // byte-enable merge
        req(0, 1'b1, BASE[0] + 32'h20, 4'hF, 32'hFFFF_FFFF);
        req(0, 1'b1, BASE[0] + 32'h20, 4'b0101, 32'h1122_3344);
        req(0, 1'b1, BASE[0] + 32'h20, 4'b0000, 32'h5555_5555);
        req(0, 1'b0, BASE[0] + 32'h20, 4'h0, 32'h0);
        idle(0);
        repeat (3) @(negedge clk);

        // range errors around base 0x8000_0000; out-of-range store must not alias word 0
        req(0, 1'b1, 32'h8000_0000, 4'hF, 32'h5A5A_A5A5);
        req(0, 1'b0, 32'h8001_0000, 4'h0, 32'h0);
        req(0, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0);
        req(0, 1'b1, 32'h8001_0000, 4'hF, 32'hFFFF_FFFF);
        req(0, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
        idle(0);
        repeat (3) @(negedge clk);

        // wait=3: rdy low for three cycles, held request accepted in the response cycle
        req(1, 1'b1, BASE[1] + 32'h8, 4'hF, 32'hCAFE_F00D);
        idle(1);
        repeat (6) @(negedge clk);
        set_req(1, 1'b0, BASE[1] + 32'h8, 4'h0, 32'h0);
        wait_accept(1, 1'b1);
        set_req(1, 1'b1, BASE[1] + 32'hC, 4'hF, 32'h0BAD_C0DE);
        for (int i = 0; i < 3; i++) begin
            check("wait_rdy_low", 1, 32'(req_rdy[1]), 32'd0);
            check("wait_vld_low", 1, 32'(resp_vld[1]), 32'd0);
            @(negedge clk);
        end
        check("wait_rdy_high", 1, 32'(req_rdy[1]), 32'd1);
        check("wait_vld_high", 1, 32'(resp_vld[1]), 32'd1);
        wait_accept(1, 1'b1);
        idle(1);
        repeat (6) @(negedge clk);

        // wait=5: reset while in WAIT drops the load; the earlier store survives
        req(2, 1'b1, BASE[2] + 32'h8, 4'hF, 32'h1357_9BDF);
        idle(2);
        repeat (7) @(negedge clk);
        set_req(2, 1'b0, BASE[2] + 32'h8, 4'h0, 32'h0);
        d0 = drop_cnt;
        wait_accept(2, 1'b0);
        idle(2);
        @(negedge clk);
        rst_n[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        check_reset_outputs(2);
        repeat (10) @(negedge clk);
        check("dropped_resp_count", 2, 32'(drop_cnt - d0), 32'd0);
        req(2, 1'b0, BASE[2] + 32'h8, 4'h0, 32'h0);
        idle(2);
        repeat (8) @(negedge clk);

        // randomized traffic per configuration
        for (int k = 0; k < NI; k++) begin
            words = 1 << (MS[k] - 2);
            for (int i = 0; i < 6; i++) begin
                pa[i] = BASE[k] + 32'(4 * $urandom_range(0, words - 1));
                req(k, 1'b1, pa[i], 4'hF, $urandom);
            end
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        addr = BASE[k] + (32'd1 << MS[k]) + 32'(4 * $urandom_range(0, 3));
                    else
                        addr = BASE[k] - 32'(4 * $urandom_range(1, 4));
                end else begin
                    addr = pa[$urandom_range(0, 5)];
                end
                addr[1:0] = 2'($urandom_range(0, 3));
                req(k, 1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom);
                if ($urandom_range(0, 2) == 0) begin
                    idle(k);
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                end
            end
            idle(k);
            repeat (WC[k] + 4) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("pending_responses", 0, 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xrv1_dmem_resp.md
# xrv1_dmem_resp

Synthesizable single-outstanding responder for the XRV1 data-memory request/response interface. It is the far end of the core's dmem port: it accepts load/store requests, holds a word-organised on-chip SRAM, inserts a programmable number of wait states and returns exactly one in-order response per request. Out-of-range accesses produce a response flagged with `dmem_resp_err_o`. This block replaces the simulation TCM model on the data side in synthesizable builds.

## Interface
- `mem_size_p`, 16: log2 of memory size in bytes; word count = 2^(mem_size_p-2); range 4..20.
- `base_addr_p`, 32'h0000_0000: byte address of word 0; must be aligned to 2^mem_size_p.
- `wait_cycles_p`, 0: extra cycles between accept and response; range 0..15.

- `clk_i` in 1: the only clock; all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `dmem_req_vld_i` in 1: request valid.
- `dmem_req_rdy_o` out 1: request ready; transfer on `vld && rdy`.
- `dmem_req_addr_i` in 32: byte address; bits [1:0] ignored.
- `dmem_req_w_en_i` in 1: 1 = store, 0 = load.
- `dmem_req_w_be_i` in 4: store byte enables; bit k selects data[8k+7:8k].
- `dmem_req_w_data_i` in 32: store data.
- `dmem_resp_vld_o` out 1: one-cycle response pulse; no backpressure.
- `dmem_resp_err_o` out 1: response is an error; valid only with `dmem_resp_vld_o`.
- `dmem_resp_r_data_o` out 32: load data; valid only with `dmem_resp_vld_o`.

## Operation
- FSM states IDLE, WAIT, RESP.
- In range: `(addr - base_addr_p) < 2^mem_size_p` (32-bit unsigned subtract, wrap discarded). Word index = offset[mem_size_p-1:2].
- Accept (IDLE or RESP with `vld && rdy`):
  - store in range: bytes with be=1 written at the accept edge; be=4'b0000 is a legal no-op store.
  - load in range: addressed word latched into the response-data register at the accept edge.
  - out of range: no write; response-data register = 0; error flag latched = 1.
  - wait counter loaded with `wait_cycles_p`; next state WAIT if `wait_cycles_p>0`, else RESP.
- WAIT: counter decrements each cycle; at 1 -> RESP.
- RESP: `dmem_resp_vld_o=1` for this cycle; `err` and `r_data` driven from latched values. Next state IDLE, or a new accept (above) if `vld` is high.
- Store responses: `vld=1`, `r_data=0`, `err` per range check.
- `dmem_req_rdy_o = (state==IDLE) || (state==RESP)`; combinational from state only, never from `vld`.
- SRAM contents not reset and not initialised.

## Timing
- Reset (`rst_i=0` at an edge): state IDLE, counter 0, `resp_vld_o=0`, `resp_err_o=0`, `resp_r_data_o=0`, `req_rdy_o=1` the cycle after. Reset dominates any accept in the same cycle.
- Reset mid-operation (WAIT or RESP): pending response dropped, never issued; a store accepted before reset stays committed.
- Latency: request accepted at edge N -> `resp_vld_o` high in cycle N+1+`wait_cycles_p`, exactly one cycle.
- Throughput: 1 req/cycle when `wait_cycles_p=0`; otherwise one per `wait_cycles_p+1` cycles.
- Load immediately after store to same word (accepted in the response cycle of the store) returns the new data.
- `vld` held while `rdy=0`: request not consumed; requester must hold address/data stable.
- Responses strictly in request order; at most one outstanding.

## Test plan
- Reset then idle: `rst_i=0` two cycles -> `rdy=1`, `resp_vld=0`, `err=0`, `r_data=0`; no response without a request.
- wait=0, store 0xDEADBEEF be=4'hF @0x10, load @0x10 back-to-back -> store resp cycle N+1 (`r_data=0`, `err=0`), load resp cycle N+2 `r_data=0xDEADBEEF`.
- Byte enables: store 0xFFFFFFFF be=4'hF, then 0x11223344 be=4'b0101 @0x20, load -> 0xFF22FF44.
- wait=3: load accepted edge N -> `rdy=0` cycles N+1..N+3, `resp_vld=1` only in cycle N+4, `rdy=1` in N+4; second request held with `vld=1` accepted at end of N+4.
- Range error, mem_size_p=16, base 0x8000_0000: load @0x8001_0000 and @0x7FFF_FFFC -> `err=1`, `r_data=0`; store @0x8001_0000 then load @0x8000_0000 -> original data unchanged.
- Reset in WAIT (wait=5, reset 2 cycles after accept) -> no `resp_vld` ever for that request; a prior store remains readable after reset.
